mult_16bit_arbiter: RTL and testbench
=====================================

Name: mult_16bit_arbiter

Overview:
- Shares one pipelined mult_16bit datapath among N_REQ requesters.
- Uses round-robin arbitration with a valid/ready request handshake.
- Drives the multiplier operand ports, waits a fixed latency, captures the 32-bit product and returns it tagged with the requester ID.
- Sits between client blocks and a single mult_16bit instance; only one multiply is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; ceil(log2(N_REQ)), minimum 1.
- MULT_LATENCY, 2, clk edges from operands presented on mult_a/mult_b to a valid mult_product (at least 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request strobe.
- req_a  in  16*N_REQ  operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*N_REQ  operand B; same packing as req_a.
- req_ready  out  N_REQ  one-hot grant; the handshake completes when req_valid[i] and req_ready[i] are both high.
- mult_a  out  16  operand A to mult_16bit (registered).
- mult_b  out  16  operand B to mult_16bit (registered).
- mult_product  in  32  product from mult_16bit.
- resp_valid  out  1  one-cycle pulse; resp_product and resp_id are valid.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_product  out  32  captured product.
- busy  out  1  high while a multiply is in flight (state WAIT).

Behaviour:
- Reset values:
  - req_ready = 0, mult_a = 0, mult_b = 0, resp_valid = 0, resp_id = 0, resp_product = 0, busy = 0.
  - State = IDLE, round-robin pointer = 0, latency counter = 0.
- State IDLE:
  - Grant the first asserted req_valid found by scanning from the pointer upward, wrapping modulo N_REQ.
  - req_ready is combinational, at most one bit high, and only in IDLE.
  - No req_valid asserted: req_ready = 0 and the block stays in IDLE.
- Accept edge E0 (handshake true):
  - mult_a/mult_b load the granted requester's operands.
  - The ID latches.
  - The pointer becomes (grant + 1) mod N_REQ.
  - The counter loads MULT_LATENCY.
  - State goes to WAIT and busy rises.
- State WAIT:
  - The counter decrements each edge and req_ready = 0.
  - mult_a/mult_b hold their values.
  - At the edge where the counter reaches 0 (edge E0 + MULT_LATENCY):
    - resp_product loads mult_product and resp_id loads the latched ID.
    - resp_valid goes to 1 and state returns to IDLE.
- Latency and throughput:
  - resp_valid is high for exactly the one cycle following edge E0 + MULT_LATENCY.
  - A new grant may be issued in that same cycle, so back-to-back throughput is one multiply per MULT_LATENCY + 1 cycles.
- Responses have no backpressure; the consumer must take resp_* during the resp_valid cycle.
- After a response, resp_product and resp_id hold their values until the next response; mult_a/mult_b hold until the next accept.
- A requester dropping req_valid while not granted has no effect; requests are never queued internally.
- Arithmetic: unsigned 16x16 -> 32 with no truncation. The block does not modify the product, and 16'hFFFF operands pass unchanged.
- Reset mid-operation (in WAIT): the in-flight result is discarded, no resp_valid is produced, and all outputs, the pointer and state return to their reset values on that edge.
- Reset has priority over a simultaneous handshake; req_ready is 0 while reset is high.

Test Plan:
- Reset then a single request: req0 with a=524, b=5 -> accepted at E0; resp_valid pulses in the cycle after E0+2 with resp_product=2620 and resp_id=0; busy is high for 2 cycles.
- All four requesters valid continuously, each with distinct operands (e.g. req_i: a=7, b=2620+i) -> grants in order 0,1,2,3,0; each response carries the matching ID and product; one response per 3 cycles.
- Pointer wrap: after req3 is granted, req1 and req3 are valid -> req1 is granted first; req3 is granted next.
- Boundary operands: a=60340, b=60340 -> resp_product=32'hD903F690; a=16'hFFFF, b=2 -> resp_product=32'h0001FFFE.
- reset asserted one cycle after the accept of a=18340, b=3 -> no resp_valid; on release the pointer=0 and req_ready is 0 until a new req_valid arrives.
- req_valid dropped by a non-granted requester while busy -> no grant and no response for it; the next grant goes to the next valid requester by round-robin order.

Source files
------------

// File: rtl/mult_16bit_arbiter.sv
// Round-robin front end that shares one pipelined 16x16 multiplier among N_REQ
// requesters, with one multiply in flight at a time and ID-tagged responses.
module mult_16bit_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int MULT_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [15:0]           mult_a,
  output logic [15:0]           mult_b,
  input  logic [31:0]           mult_product,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_product,
  output logic                  busy
);

  localparam int CNT_W = ($clog2(MULT_LATENCY + 1) < 1) ? 1 : $clog2(MULT_LATENCY + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [15:0]       mult_a_q, mult_a_d;
  logic [15:0]       mult_b_q, mult_b_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [31:0]       resp_product_q, resp_product_d;

  logic              found_s;
  logic [ID_W-1:0]   gnt_id_s;
  logic [N_REQ-1:0]  grant_s;
  int                scan_idx_s;

  // Round-robin scan: first asserted request at or above the pointer, wrapping.
  always_comb begin
    found_s    = 1'b0;
    gnt_id_s   = '0;
    scan_idx_s = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx_s = (int'(ptr_q) + k) % N_REQ;
      if (!found_s && req_valid[scan_idx_s]) begin
        found_s  = 1'b1;
        gnt_id_s = ID_W'(scan_idx_s);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    id_d           = id_q;
    mult_a_d       = mult_a_q;
    mult_b_d       = mult_b_q;
    resp_valid_d   = 1'b0;
    resp_id_d      = resp_id_q;
    resp_product_d = resp_product_q;
    grant_s        = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          grant_s[gnt_id_s] = 1'b1;
          mult_a_d = req_a[int'(gnt_id_s)*16 +: 16];
          mult_b_d = req_b[int'(gnt_id_s)*16 +: 16];
          id_d     = gnt_id_s;
          ptr_d    = ID_W'((int'(gnt_id_s) + 1) % N_REQ);
          cnt_d    = CNT_W'(MULT_LATENCY);
          state_d  = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // The edge that takes the counter to zero is the capture edge.
        if (cnt_q == CNT_W'(1)) begin
          cnt_d          = '0;
          resp_product_d = mult_product;
          resp_id_d      = id_q;
          resp_valid_d   = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over a simultaneous handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      id_q           <= '0;
      mult_a_q       <= 16'd0;
      mult_b_q       <= 16'd0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_product_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      id_q           <= id_d;
      mult_a_q       <= mult_a_d;
      mult_b_q       <= mult_b_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_product_q <= resp_product_d;
    end
  end

  assign req_ready    = reset ? '0 : grant_s;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign busy         = (state_q == WAIT);

endmodule

// File: tb/tb_mult_16bit_arbiter.sv
// Scoreboard bench for mult_16bit_arbiter: a cycle-level reference model predicts
// grants and responses; a separate monitor pops expectations on resp_valid.
module tb_mult_16bit_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic [15:0]     mult_a, mult_b;
  logic [31:0]     mult_product;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_product;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [31:0] prod;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Bench-side multiplier: one register stage, so the product is ready for the LAT-th edge.
  always @(posedge clk) mult_product <= 32'(mult_a) * 32'(mult_b);

  mult_16bit_arbiter #(.N_REQ(N), .ID_W(IDW), .MULT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_product(mult_product),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_product(resp_product), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  // Reference model: idle/busy bookkeeping, round-robin by plain modulo scan.
  initial begin : model
    int m_ptr, m_wait, g, j;
    logic m_due;
    logic [15:0] m_a, m_b;
    logic [N-1:0] exp_ready;
    m_ptr = 0; m_wait = 0; m_due = 1'b0; m_a = 16'd0; m_b = 16'd0;
    forever begin
      @(negedge clk); #3;
      if (reset) begin
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        m_ptr = 0; m_wait = 0; m_due = 1'b0; m_a = 16'd0; m_b = 16'd0;
        sb_q.delete();
      end else begin
        chk("busy", 64'(busy), 64'(m_wait > 0));
        chk("resp_valid", 64'(resp_valid), 64'(m_due));
        chk("mult_ab", {32'd0, mult_a, mult_b}, {32'd0, m_a, m_b});
        m_due = 1'b0;
        exp_ready = '0;
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) m_due = 1'b1;
        end else begin
          g = -1;
          for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
          end
          if (g >= 0) begin
            exp_ready[g] = 1'b1;
            m_a = req_a[16*g +: 16];
            m_b = req_b[16*g +: 16];
            sb_q.push_back('{id: g, prod: 32'(m_a) * 32'(m_b)});
            m_ptr  = (g + 1) % N;
            m_wait = LAT;
          end
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
      end
    end
  end

  // Monitor: pops one expectation per response pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (resp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_product", 64'(resp_product), 64'(e.prod));
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_resp_product", 64'(resp_product), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);

    // Single request from requester 0.
    @(negedge clk); set_req(0, 16'd524, 16'd5); req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);
    #2 chk("single_product", 64'(resp_product), 64'd2620);

    // All requesters valid continuously: grants 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_req(i, 16'd7, 16'(2620 + i));
    req_valid = 4'b1111;
    repeat (15) @(negedge clk);
    // Pointer now sits just after requester 0; reissue so 3 is last served, then 1 and 3.
    req_valid = 4'b1110;
    repeat (9) @(negedge clk);
    req_valid = 4'b1010;
    repeat (6) @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Boundary operands.
    set_req(2, 16'd60340, 16'd60340); req_valid = 4'b0100;
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    #2 chk("boundary_60340sq", 64'(resp_product), 64'hD903F690);
    @(negedge clk); set_req(1, 16'hFFFF, 16'd2); req_valid = 4'b0010;
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    #2 chk("boundary_ffff_x2", 64'(resp_product), 64'h0001FFFE);

    // Reset one cycle after an accept discards the in-flight multiply.
    @(negedge clk); set_req(0, 16'd18340, 16'd3); req_valid = 4'b0001;
    @(negedge clk); req_valid = '0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    #2 chk("post_reset_product", 64'(resp_product), 64'd0);

    // Non-granted requester drops while busy; next grant goes by round-robin order.
    @(negedge clk); set_req(1, 16'd11, 16'd13); set_req(2, 16'd17, 16'd19); set_req(3, 16'd23, 16'd29);
    req_valid = 4'b0110;
    @(negedge clk); req_valid = 4'b1000;
    repeat (6) @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 7) == 0) set_req(i, 16'hFFFF, 16'($urandom));
          else set_req(i, 16'($urandom), 16'($urandom));
        end
      end
      req_valid = 4'($urandom);
      if (c == 200) reset = 1'b1;
      else reset = 1'b0;
    end
    @(negedge clk); req_valid = '0; reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
